// File: rtl/i386_bus_master.sv
// i386-style bus-cycle master: T1/T2 cycles with READY wait states, NA address pipelining,
// BS16 splitting of 32-bit cycles onto a 16-bit bus, and abort of stuck cycles after TIMEOUT T2 states.
module i386_bus_master #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter bit PIPE_EN = 1'b1
) (
    input  logic                  CLK2,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_mio,
    input  logic                  req_dc,
    input  logic                  req_lock,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     A,
    output logic [DATA_W/8-1:0]   BE,
    output logic [DATA_W-1:0]     D_out,
    output logic                  D_oe,
    input  logic [DATA_W-1:0]     D_in,
    output logic                  WR,
    output logic                  DC,
    output logic                  MIO,
    output logic                  LOCK,
    output logic                  ADS,
    input  logic                  READY,
    input  logic                  NA,
    input  logic                  BS16
);
    localparam int BE_W = DATA_W / 8;
    localparam int HB   = BE_W / 2;
    localparam int HD   = DATA_W / 2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T2P} state_t;
    state_t r_state, w_state_n;

    logic [ADDR_W-1:0] r_A;
    logic [BE_W-1:0]   r_BE;
    logic              r_WR, r_DC, r_MIO, r_ADS, r_LOCK, r_D_oe;
    logic [7:0]        r_cnt;
    logic              r_split;
    logic              r_cur_write, r_cur_lock, r_nxt_write, r_nxt_lock;
    logic [DATA_W-1:0] r_cur_wdata, r_nxt_wdata;
    logic [HD-1:0]     r_lo;
    logic              r_rsp_valid, r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_in_t2, w_accept, w_split, w_done, w_tmo, w_end, w_promote;
    logic              w_load_cur, w_load_nxt, w_pipe_ok;
    logic [BE_W-1:0]   w_cur_be;
    logic              w_ads_n, w_doe_n, w_lock_n;
    logic [7:0]        w_cnt_n;

    // Outside T2P the BE pins always carry the current cycle's enables.
    assign w_cur_be   = ~r_BE;
    assign w_in_t2    = (r_state == S_T2) || (r_state == S_T2P);
    // Splits are only taken from T2; in T2P the pins already hold the pipelined cycle.
    assign w_split    = (DATA_W == 32) && (r_state == S_T2) && !READY && !BS16 && !r_split
                        && (|w_cur_be[HB-1:0]) && (|w_cur_be[BE_W-1:HB]);
    assign w_done     = w_in_t2 && !READY && !w_split;
    assign w_tmo      = w_in_t2 && READY && (r_cnt == TMO_LAST);
    assign w_end      = w_done || w_tmo;
    assign w_promote  = (r_state == S_T2P) && w_end;
    assign w_pipe_ok  = PIPE_EN && (r_state == S_T2) && !NA && !r_split && !w_split;
    assign req_ready  = !RESET && ((r_state == S_IDLE) || w_pipe_ok);
    assign w_accept   = req_valid && req_ready;
    assign w_load_cur = w_accept && ((r_state == S_IDLE) || w_end);
    assign w_load_nxt = w_accept && !w_load_cur;

    always_comb begin
        w_state_n = r_state;
        w_ads_n   = 1'b1;
        w_doe_n   = r_D_oe;
        w_lock_n  = r_LOCK;
        w_cnt_n   = 8'd0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_n = S_T1;
            S_T1: begin
                w_state_n = S_T2;
                w_doe_n   = r_cur_write;
            end
            S_T2: begin
                if (w_split)       w_state_n = S_T1;
                else if (w_accept) w_state_n = w_end ? S_T1 : S_T2P;
                else if (w_end)    w_state_n = S_IDLE;
            end
            S_T2P:   if (w_end) w_state_n = S_T2;
            default: w_state_n = S_IDLE;
        endcase
        if (w_accept || w_split) w_ads_n = 1'b0;
        if (w_promote)                w_doe_n = r_nxt_write;
        else if (w_end || w_split)    w_doe_n = 1'b0;
        if (w_in_t2 && !w_end && !w_split) w_cnt_n = r_cnt + 8'd1;
        if (w_end && !r_cur_lock)                 w_lock_n = 1'b1;
        if ((r_state == S_IDLE) && !req_valid)    w_lock_n = 1'b1;
        if (w_accept && req_lock)                 w_lock_n = 1'b0;
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_A         <= '0;
            r_BE        <= '1;
            r_WR        <= 1'b0;
            r_DC        <= 1'b0;
            r_MIO       <= 1'b0;
            r_ADS       <= 1'b1;
            r_LOCK      <= 1'b1;
            r_D_oe      <= 1'b0;
            r_cnt       <= 8'd0;
            r_split     <= 1'b0;
            r_cur_write <= 1'b0;
            r_cur_lock  <= 1'b0;
            r_nxt_write <= 1'b0;
            r_nxt_lock  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_n;
            r_ADS       <= w_ads_n;
            r_LOCK      <= w_lock_n;
            r_D_oe      <= w_doe_n;
            r_cnt       <= w_cnt_n;
            r_rsp_valid <= w_end;
            r_rsp_err   <= w_tmo;
            r_rsp_rdata <= '0;
            if (w_done && !r_cur_write)
                r_rsp_rdata <= r_split ? {D_in[DATA_W-1:HD], r_lo} : D_in;
            if (w_split) begin
                r_split <= 1'b1;
                r_BE    <= {~w_cur_be[BE_W-1:HB], {HB{1'b1}}};
            end else if (w_end) begin
                r_split <= 1'b0;
            end
            if (w_accept) begin
                r_A   <= req_addr;
                r_BE  <= ~req_be;
                r_WR  <= req_write;
                r_DC  <= req_dc;
                r_MIO <= req_mio;
            end
            if (w_load_cur) begin
                r_cur_write <= req_write;
                r_cur_lock  <= req_lock;
            end else if (w_load_nxt) begin
                r_nxt_write <= req_write;
                r_nxt_lock  <= req_lock;
            end else if (w_promote) begin
                r_cur_write <= r_nxt_write;
                r_cur_lock  <= r_nxt_lock;
            end
        end
    end

    always_ff @(posedge CLK2) begin
        if (w_load_cur)      r_cur_wdata <= req_wdata;
        else if (w_promote)  r_cur_wdata <= r_nxt_wdata;
        if (w_load_nxt)      r_nxt_wdata <= req_wdata;
        if (w_split)         r_lo        <= D_in[HD-1:0];
    end

    assign A         = r_A;
    assign BE        = r_BE;
    assign WR        = r_WR;
    assign DC        = r_DC;
    assign MIO       = r_MIO;
    assign ADS       = r_ADS;
    assign LOCK      = r_LOCK;
    assign D_oe      = r_D_oe;
    assign D_out     = r_cur_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_i386_bus_master.sv
// Directed bench for i386_bus_master: basic read, BS16 splits, NA pipelining, timeout, LOCK and reset.
module tb_i386_bus_master;
    logic        CLK2 = 1'b0;
    logic        RESET;
    logic        req_valid, req_ready, req_write, req_mio, req_dc, req_lock;
    logic [29:0] req_addr, A;
    logic [3:0]  req_be, BE;
    logic [31:0] req_wdata, rsp_rdata, D_out, D_in;
    logic        rsp_valid, rsp_err, D_oe, WR, DC, MIO, LOCK, ADS, READY, NA, BS16;
    int          checks = 0;
    int          failures = 0;

    i386_bus_master #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(4), .PIPE_EN(1'b1)) dut (
        .CLK2(CLK2), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_mio(req_mio),
        .req_dc(req_dc), .req_lock(req_lock), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .A(A), .BE(BE), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .WR(WR), .DC(DC), .MIO(MIO), .LOCK(LOCK), .ADS(ADS),
        .READY(READY), .NA(NA), .BS16(BS16)
    );

    always #5 CLK2 = ~CLK2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge CLK2);
        #2;
    endtask

    task automatic req(input logic w, input logic lk, input logic [29:0] ad, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_mio   = 1'b1;
        req_dc    = 1'b1;
        req_lock  = lk;
        req_addr  = ad;
        req_be    = 4'hF;
        req_wdata = wd;
    endtask

    initial begin
        RESET = 1'b1; req_valid = 1'b0; READY = 1'b1; NA = 1'b1; BS16 = 1'b1; D_in = '0;
        req_write = 1'b0; req_mio = 1'b0; req_dc = 1'b0; req_lock = 1'b0;
        req_addr = '0; req_be = '0; req_wdata = '0;
        go(); go(); #1;
        chk("rst_ads", ADS, 1);
        chk("rst_lock", LOCK, 1);
        chk("rst_be", BE, 4'hF);
        chk("rst_a", A, 0);
        chk("rst_def", {WR, DC, MIO}, 0);
        chk("rst_doe", D_oe, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        RESET = 1'b0;
        go(); #1;
        chk("idle_ready", req_ready, 1);

        // basic read, READY on the second T2
        req(1'b0, 1'b0, 30'h1234, 32'h0); #1;
        chk("rd_accept", req_ready, 1);
        go(); req_valid = 1'b0; #1;
        chk("rd_ads_lo", ADS, 0);
        chk("rd_addr", A, 30'h1234);
        chk("rd_be", BE, 4'h0);
        chk("rd_def", {WR, DC, MIO}, 3'b011);
        chk("rd_ready_t1", req_ready, 0);
        go(); #1;
        chk("rd_ads_hi", ADS, 1);
        chk("rd_no_rsp", rsp_valid, 0);
        go(); READY = 1'b0; D_in = 32'hDEADBEEF; #1;
        chk("rd_wait", rsp_valid, 0);
        go(); READY = 1'b1; D_in = '0; #1;
        chk("rd_rsp", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_err", rsp_err, 0);
        chk("rd_idle", req_ready, 1);
        go(); #1;
        chk("rd_pulse", rsp_valid, 0);

        // split write on a 16-bit bus
        req(1'b1, 1'b0, 30'h2000, 32'hCAFEF00D); #1;
        go(); req_valid = 1'b0; #1;
        chk("sw_ads1", ADS, 0);
        chk("sw_be1", BE, 4'h0);
        chk("sw_wr", WR, 1);
        go(); READY = 1'b0; BS16 = 1'b0; #1;
        chk("sw_doe1", D_oe, 1);
        chk("sw_dout", D_out, 32'hCAFEF00D);
        go(); READY = 1'b1; BS16 = 1'b1; #1;
        chk("sw_ads2", ADS, 0);
        chk("sw_be2", BE, 4'b0011);
        chk("sw_a2", A, 30'h2000);
        chk("sw_no_rsp", rsp_valid, 0);
        go(); READY = 1'b0; #1;
        chk("sw_ads2_hi", ADS, 1);
        chk("sw_doe2", D_oe, 1);
        go(); READY = 1'b1; #1;
        chk("sw_rsp", rsp_valid, 1);
        chk("sw_rdata", rsp_rdata, 0);
        chk("sw_doe_off", D_oe, 0);
        go(); #1;
        chk("sw_one_rsp", rsp_valid, 0);

        // split read merges both halves
        req(1'b0, 1'b0, 30'h2004, 32'h0); #1;
        go(); req_valid = 1'b0;
        go(); READY = 1'b0; BS16 = 1'b0; D_in = 32'h0000_5678;
        go(); READY = 1'b1; BS16 = 1'b1; D_in = '0; #1;
        chk("sr_no_rsp", rsp_valid, 0);
        go(); READY = 1'b0; D_in = 32'h1234_0000;
        go(); READY = 1'b1; D_in = '0; #1;
        chk("sr_rsp", rsp_valid, 1);
        chk("sr_rdata", rsp_rdata, 32'h12345678);

        // pipelined back-to-back reads
        go();
        req(1'b0, 1'b0, 30'h100, 32'h0); #1;
        go(); req_addr = 30'h101; #1;
        chk("pp_ready_t1", req_ready, 0);
        go(); NA = 1'b0; #1;
        chk("pp_ready_t2", req_ready, 1);
        chk("pp_a1", A, 30'h100);
        go(); NA = 1'b1; req_valid = 1'b0; READY = 1'b0; D_in = 32'hAAAA0001; #1;
        chk("pp_ads2", ADS, 0);
        chk("pp_a2", A, 30'h101);
        chk("pp_no_rsp", rsp_valid, 0);
        go(); D_in = 32'hBBBB0002; #1;
        chk("pp_ads_once", ADS, 1);
        chk("pp_rsp1", rsp_valid, 1);
        chk("pp_rdata1", rsp_rdata, 32'hAAAA0001);
        go(); READY = 1'b1; D_in = '0; #1;
        chk("pp_rsp2", rsp_valid, 1);
        chk("pp_rdata2", rsp_rdata, 32'hBBBB0002);
        chk("pp_idle", req_ready, 1);
        go(); #1;
        chk("pp_end", rsp_valid, 0);

        // timeout with READY held high
        req(1'b0, 1'b0, 30'h300, 32'h0); D_in = 32'hFFFFFFFF; #1;
        go(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            go(); #1;
            chk("to_wait", rsp_valid, 0);
            chk("to_ads", ADS, 1);
        end
        go(); #1;
        chk("to_rsp", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_idle", req_ready, 1);
        chk("to_ads_hi", ADS, 1);
        go(); D_in = '0; #1;
        chk("to_err_pulse", rsp_err, 0);

        // locked read followed by unlocked write
        req(1'b0, 1'b1, 30'h400, 32'h0); #1;
        chk("lk_pre", LOCK, 1);
        go(); req_valid = 1'b0; #1;
        chk("lk_t1", LOCK, 0);
        go(); READY = 1'b0; #1;
        chk("lk_t2", LOCK, 0);
        go(); READY = 1'b1; req(1'b1, 1'b0, 30'h401, 32'h55AA55AA); #1;
        chk("lk_rsp1", rsp_valid, 1);
        chk("lk_hold", LOCK, 0);
        go(); req_valid = 1'b0; #1;
        chk("lk_t1b", LOCK, 0);
        go(); READY = 1'b0; #1;
        chk("lk_t2b", LOCK, 0);
        go(); READY = 1'b1; #1;
        chk("lk_release", LOCK, 1);
        chk("lk_rsp2", rsp_valid, 1);

        // reset in T2 of a locked write
        go();
        req(1'b1, 1'b1, 30'h500, 32'h12345678); #1;
        go(); req_valid = 1'b0;
        go(); #1;
        chk("rs_doe_pre", D_oe, 1);
        chk("rs_lock_pre", LOCK, 0);
        RESET = 1'b1; #1;
        chk("rs_doe", D_oe, 0);
        chk("rs_ads", ADS, 1);
        chk("rs_lock", LOCK, 1);
        chk("rs_be", BE, 4'hF);
        go(); RESET = 1'b0; #1;
        chk("rs_no_rsp1", rsp_valid, 0);
        go(); #1;
        chk("rs_no_rsp2", rsp_valid, 0);
        chk("rs_idle", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
